// File: rtl/ppc_crack_pkg.sv
// Shared encodings and helpers for the decode-stage instruction cracker.
package ppc_crack_pkg;

  localparam int unsigned KIND_W = 2;
  localparam int unsigned GPR_W  = 5;

  localparam logic [GPR_W-1:0] LAST_GPR = 5'd31;

  typedef enum logic [KIND_W-1:0] {
    KIND_PLAIN = 2'b00,
    KIND_UPD   = 2'b01,
    KIND_MW    = 2'b10,
    KIND_RSVD  = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UPD  = 2'b01,
    S_MW   = 2'b10
  } state_e;

  // Per-micro-op control flags handed to the cracker mux
  typedef struct packed {
    logic fetch_stall;
    logic uop_first;
    logic uop_last;
    logic uop_upd;
    logic int_inject;
  } uop_ctl_t;

  // Reserved kind decodes as a plain instruction
  function automatic kind_e norm_kind(input logic [KIND_W-1:0] raw);
    kind_e k;
    k = kind_e'(raw);
    if (k == KIND_RSVD) k = KIND_PLAIN;
    return k;
  endfunction

endpackage

// File: rtl/uop_crack_sequencer_mw_step_gen.sv
// Register/displacement stepper for load/store-multiple micro-op sequences.
module mw_step_gen
  import ppc_crack_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 16,
  parameter int unsigned DISP_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [GPR_W-1:0]   load_rt,
  input  logic [D_WIDTH-1:0] load_d,
  output logic [GPR_W-1:0]   rt,
  output logic [D_WIDTH-1:0] d,
  output logic               last_o
);

  // Load points at the second word; step advances one word; otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt <= '0;
      d  <= '0;
    end else if (load) begin
      rt <= GPR_W'(load_rt + GPR_W'(1));
      d  <= D_WIDTH'(load_d + D_WIDTH'(DISP_STEP));
    end else if (step) begin
      rt <= GPR_W'(rt + GPR_W'(1));
      d  <= D_WIDTH'(d + D_WIDTH'(DISP_STEP));
    end
  end

  // Final word of the sequence is always the last GPR
  assign last_o = (rt == LAST_GPR);

endmodule

// File: rtl/uop_crack_sequencer.sv
// Steps update-form and multiword instructions through their micro-ops,
// holds fetch mid-sequence and gates interrupts to instruction boundaries.
module uop_crack_sequencer
  import ppc_crack_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned D_WIDTH   = 16,
  parameter int unsigned DISP_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  input  logic [KIND_W-1:0]  issue_kind,
  input  logic [GPR_W-1:0]   issue_rt,
  input  logic [D_WIDTH-1:0] issue_d,
  input  logic               issue_nop,
  input  logic               hold,
  input  logic               int_req,
  output logic               fetch_stall,
  output logic               uop_first,
  output logic               uop_last,
  output logic               uop_upd,
  output logic [GPR_W-1:0]   uop_rt,
  output logic [D_WIDTH-1:0] uop_d,
  output logic               int_inject,
  output logic               int_ack
);

  // The sequencer never sees the PC itself; the width only has to be sane
  if (PC_WIDTH == 0) begin : g_pc_width_bad
    $error("PC_WIDTH must be nonzero");
  end

  state_e             state_q;
  state_e             state_d;
  kind_e              kind;
  logic               mw_load;
  logic               mw_step;
  logic               mw_last;
  logic [GPR_W-1:0]   rt_r;
  logic [D_WIDTH-1:0] d_r;
  uop_ctl_t           ctl;
  logic [GPR_W-1:0]   rt_c;
  logic [D_WIDTH-1:0] d_c;

  assign kind = norm_kind(issue_kind);

  // Counter controls: load on a multi-word issue, step while in MW short of the end
  assign mw_load = !hold && (state_q == S_IDLE) && issue_valid &&
                   (kind == KIND_MW) && (issue_rt != LAST_GPR);
  assign mw_step = !hold && (state_q == S_MW) && !mw_last;

  mw_step_gen #(
    .D_WIDTH   (D_WIDTH),
    .DISP_STEP (DISP_STEP)
  ) u_mw_step_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mw_load),
    .step    (mw_step),
    .load_rt (issue_rt),
    .load_d  (issue_d),
    .rt      (rt_r),
    .d       (d_r),
    .last_o  (mw_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; hold freezes the sequencer
  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        S_IDLE: begin
          if (issue_valid) begin
            if (kind == KIND_UPD)    state_d = S_UPD;
            else if (mw_load)        state_d = S_MW;
          end
        end
        S_UPD:   state_d = S_IDLE;
        S_MW:    if (mw_last) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from state, counters and the issuing instruction
  always_comb begin
    ctl  = '0;
    rt_c = '0;
    d_c  = '0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (issue_valid) begin
            ctl.uop_first = 1'b1;
            case (kind)
              KIND_UPD: ctl.fetch_stall = 1'b1;
              KIND_MW: begin
                rt_c = issue_rt;
                d_c  = issue_d;
                if (issue_rt == LAST_GPR) ctl.uop_last    = 1'b1;
                else                      ctl.fetch_stall = 1'b1;
              end
              default: begin
                ctl.uop_last   = 1'b1;
                ctl.int_inject = issue_nop && int_req && !hold;
              end
            endcase
          end
        end
        S_UPD: begin
          ctl.uop_upd  = 1'b1;
          ctl.uop_last = 1'b1;
        end
        S_MW: begin
          rt_c = rt_r;
          d_c  = d_r;
          if (mw_last) ctl.uop_last    = 1'b1;
          else         ctl.fetch_stall = 1'b1;
        end
        default: ctl = '0;
      endcase
    end
  end

  assign fetch_stall = ctl.fetch_stall;
  assign uop_first   = ctl.uop_first;
  assign uop_last    = ctl.uop_last;
  assign uop_upd     = ctl.uop_upd;
  assign int_inject  = ctl.int_inject;
  assign int_ack     = ctl.int_inject;
  assign uop_rt      = rt_c;
  assign uop_d       = d_c;

endmodule

// File: tb/tb_uop_crack_sequencer.sv
// Directed bench for uop_crack_sequencer.
module tb_uop_crack_sequencer;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [1:0]  issue_kind;
  logic [4:0]  issue_rt;
  logic [15:0] issue_d;
  logic        issue_nop;
  logic        hold;
  logic        int_req;
  logic        fetch_stall;
  logic        uop_first;
  logic        uop_last;
  logic        uop_upd;
  logic [4:0]  uop_rt;
  logic [15:0] uop_d;
  logic        int_inject;
  logic        int_ack;

  int n_cmp = 0;
  int n_err = 0;

  uop_crack_sequencer #(
    .PC_WIDTH  (32),
    .D_WIDTH   (16),
    .DISP_STEP (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_kind  (issue_kind),
    .issue_rt    (issue_rt),
    .issue_d     (issue_d),
    .issue_nop   (issue_nop),
    .hold        (hold),
    .int_req     (int_req),
    .fetch_stall (fetch_stall),
    .uop_first   (uop_first),
    .uop_last    (uop_last),
    .uop_upd     (uop_upd),
    .uop_rt      (uop_rt),
    .uop_d       (uop_d),
    .int_inject  (int_inject),
    .int_ack     (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_uop(input string tag, input logic fs, input logic f, input logic l,
                            input logic u, input logic [4:0] rt, input logic [15:0] d,
                            input logic inj);
    chk({tag, ".fetch_stall"}, 32'(fetch_stall), 32'(fs));
    chk({tag, ".first"},       32'(uop_first),   32'(f));
    chk({tag, ".last"},        32'(uop_last),    32'(l));
    chk({tag, ".upd"},         32'(uop_upd),     32'(u));
    chk({tag, ".rt"},          32'(uop_rt),      32'(rt));
    chk({tag, ".d"},           32'(uop_d),       32'(d));
    chk({tag, ".inject"},      32'(int_inject),  32'(inj));
    chk({tag, ".ack"},         32'(int_ack),     32'(inj));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [4:0] rt,
                       input logic [15:0] d, input logic nop);
    issue_valid = v;
    issue_kind  = k;
    issue_rt    = rt;
    issue_d     = d;
    issue_nop   = nop;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 1'b0;
    int_req = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 16'h0, 1'b0);

    // Reset: outputs forced low even with a valid plain issue present
    #1;
    drive(1'b1, 2'b00, 5'd3, 16'h1234, 1'b0);
    expect_uop("reset", 0, 0, 0, 0, 5'd0, 16'h0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Plain add: one micro-op, first and last, no stall
    drive(1'b1, 2'b00, 5'd3, 16'h1234, 1'b0);
    expect_uop("plain", 0, 1, 1, 0, 5'd0, 16'h0, 0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    expect_uop("plain_idle", 0, 0, 0, 0, 5'd0, 16'h0, 0);

    // Update form: memory op then address update
    drive(1'b1, 2'b01, 5'd4, 16'h0008, 1'b0);
    expect_uop("upd_c0", 1, 1, 0, 0, 5'd0, 16'h0, 0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    expect_uop("upd_c1", 0, 0, 1, 1, 5'd0, 16'h0, 0);
    tick();
    expect_uop("upd_c2", 0, 0, 0, 0, 5'd0, 16'h0, 0);

    // lmw rt=29 d=0x10: three words
    drive(1'b1, 2'b10, 5'd29, 16'h0010, 1'b0);
    expect_uop("lmw29_0", 1, 1, 0, 0, 5'd29, 16'h0010, 0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    expect_uop("lmw29_1", 1, 0, 0, 0, 5'd30, 16'h0014, 0);
    tick();
    expect_uop("lmw29_2", 0, 0, 1, 0, 5'd31, 16'h0018, 0);
    tick();
    expect_uop("lmw29_idle", 0, 0, 0, 0, 5'd0, 16'h0, 0);

    // stmw rt=30 d=0xFFFC with hold on the second micro-op; displacement wraps
    drive(1'b1, 2'b10, 5'd30, 16'hFFFC, 1'b0);
    expect_uop("stmw_0", 1, 1, 0, 0, 5'd30, 16'hFFFC, 0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    hold = 1'b1;
    #1;
    expect_uop("stmw_h1", 0, 0, 1, 0, 5'd31, 16'h0000, 0);
    tick();
    expect_uop("stmw_h2", 0, 0, 1, 0, 5'd31, 16'h0000, 0);
    tick();
    expect_uop("stmw_h3", 0, 0, 1, 0, 5'd31, 16'h0000, 0);
    tick();
    hold = 1'b0;
    #1;
    expect_uop("stmw_h4", 0, 0, 1, 0, 5'd31, 16'h0000, 0);
    tick();
    expect_uop("stmw_idle", 0, 0, 0, 0, 5'd0, 16'h0, 0);

    // lmw rt=31: single word, stays idle
    drive(1'b1, 2'b10, 5'd31, 16'h0040, 1'b0);
    expect_uop("lmw31", 0, 1, 1, 0, 5'd31, 16'h0040, 0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    expect_uop("lmw31_idle", 0, 0, 0, 0, 5'd0, 16'h0, 0);

    // Interrupt pending across lmw rt=28; NOPs seen mid-sequence are ignored
    int_req = 1'b1;
    drive(1'b1, 2'b10, 5'd28, 16'h0000, 1'b0);
    expect_uop("int_mw0", 1, 1, 0, 0, 5'd28, 16'h0000, 0);
    tick();
    drive(1'b1, 2'b00, 5'd0, 16'h0, 1'b1);
    expect_uop("int_mw1", 1, 0, 0, 0, 5'd29, 16'h0004, 0);
    tick();
    expect_uop("int_mw2", 1, 0, 0, 0, 5'd30, 16'h0008, 0);
    tick();
    expect_uop("int_mw3", 0, 0, 1, 0, 5'd31, 16'h000C, 0);
    tick();
    hold = 1'b1;
    #1;
    expect_uop("int_nop_held", 0, 1, 1, 0, 5'd0, 16'h0, 0);
    hold = 1'b0;
    #1;
    expect_uop("int_nop", 0, 1, 1, 0, 5'd0, 16'h0, 1);
    tick();
    int_req = 1'b0;
    #1;
    expect_uop("int_done", 0, 1, 1, 0, 5'd0, 16'h0, 0);
    tick();

    // Reserved kind behaves as plain
    drive(1'b1, 2'b11, 5'd5, 16'h0033, 1'b0);
    expect_uop("rsvd", 0, 1, 1, 0, 5'd0, 16'h0, 0);
    tick();

    // Reset asserted mid-MW at rt_r=20
    drive(1'b1, 2'b10, 5'd17, 16'h0100, 1'b0);
    expect_uop("rst_mw0", 1, 1, 0, 0, 5'd17, 16'h0100, 0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    tick();
    tick();
    expect_uop("rst_mw20", 1, 0, 0, 0, 5'd20, 16'h010C, 0);
    rst_n = 1'b0;
    #1;
    expect_uop("rst_mid", 0, 0, 0, 0, 5'd0, 16'h0, 0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 2'b00, 5'd9, 16'h0002, 1'b0);
    expect_uop("rst_plain", 0, 1, 1, 0, 5'd0, 16'h0, 0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    expect_uop("rst_idle", 0, 0, 0, 0, 5'd0, 16'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
